// File: rtl/eth_tx_fcs_append_pkg.sv
// Shared constants and types for the Ethernet TX/RX FCS datapath.
// Reflected CRC-32 parameters plus the TX FCS-append state encoding.
package eth_tx_fcs_append_pkg;

    localparam int          datalen         = 8;
    localparam int          crc_len         = 32;
    localparam logic [31:0] crc_poly        = 32'h04C11DB7;
    localparam logic [31:0] crc_poly_refl   = 32'hEDB88320;
    localparam logic [31:0] crc_init        = 32'hFFFFFFFF;
    localparam logic [31:0] crc_residue     = 32'hDEBB20E3;
    localparam int          eth_min_payload = 60;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } fcs_state_t;

endpackage

// File: rtl/eth_tx_fcs_append_if.sv
// Byte stream with valid/ready/last; a beat transfers on a cycle where valid && ready.
// The master holds data/valid/last stable while valid && !ready.
interface eth_tx_fcs_append_if;
    import eth_tx_fcs_append_pkg::*;

    logic [datalen-1:0] data;
    logic               valid;
    logic               last;
    logic               ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/eth_tx_fcs_append_crc32_byte_step.sv
// One byte of reflected CRC-32 (LSB-first), purely combinational.
// Shared by the TX FCS append stage and the RX FCS checker.
module crc32_byte_step
    import eth_tx_fcs_append_pkg::*;
(
    input  logic [crc_len-1:0] i_crc_in,
    input  logic [datalen-1:0] i_byte_in,
    output logic [crc_len-1:0] o_crc_out
);

    logic [crc_len-1:0] w_acc;

    always_comb begin
        w_acc = i_crc_in ^ {{(crc_len-datalen){1'b0}}, i_byte_in};
        for (int k = 0; k < 8; k++) begin
            w_acc = w_acc[0] ? ((w_acc >> 1) ^ crc_poly_refl) : (w_acc >> 1);
        end
        o_crc_out = w_acc;
    end

endmodule

// File: rtl/eth_tx_fcs_append.sv
// Ethernet TX stage: forwards payload, optionally zero-pads to MIN_LEN, appends CRC-32 FCS.
// Single output register; the FSM advances only on cycles the output register may load.
module eth_tx_fcs_append
    import eth_tx_fcs_append_pkg::*;
#(
    parameter int DATALEN = 8,
    parameter int CRC_LEN = 32,
    parameter int MIN_LEN = 60,
    parameter int PAD_EN  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    eth_tx_fcs_append_if.slave  s_if,
    eth_tx_fcs_append_if.master m_if,
    output logic                busy,
    output fcs_state_t          o_state
);

    localparam logic [11:0] LP_MIN_LEN = 12'(MIN_LEN);

    fcs_state_t         r_state;
    logic [CRC_LEN-1:0] r_crc;
    logic [CRC_LEN-1:0] r_fcs;
    logic [11:0]        r_cnt;
    logic [1:0]         r_idx;
    logic [DATALEN-1:0] r_m_data;
    logic               r_m_valid;
    logic               r_m_last;

    logic               w_load;
    logic               w_s_ready;
    logic               w_accept;
    logic [7:0]         w_step_byte;
    logic [31:0]        w_crc_next;
    logic [11:0]        w_cnt_inc;
    logic [11:0]        w_cnt_after;
    logic               w_need_pad;

    assign w_load      = !r_m_valid || m_if.ready;
    // Gated by rst_n so the source sees no ready while reset is held.
    assign w_s_ready   = rst_n && w_load && ((r_state == IDLE) || (r_state == DATA));
    assign w_accept    = s_if.valid && w_s_ready;
    assign w_step_byte = (r_state == PAD) ? 8'h00 : s_if.data;
    assign w_cnt_inc   = (r_cnt == 12'hFFF) ? r_cnt : 12'(r_cnt + 12'd1);
    assign w_cnt_after = (r_state == IDLE) ? 12'd1 : w_cnt_inc;
    assign w_need_pad  = (PAD_EN != 0) && (w_cnt_after < LP_MIN_LEN);

    crc32_byte_step u_crc_step (
        .i_crc_in  (r_crc),
        .i_byte_in (w_step_byte),
        .o_crc_out (w_crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_crc     <= crc_init;
            r_fcs     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DATA: begin
                    if (w_accept) begin
                        r_m_data  <= s_if.data;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b0;
                        r_crc     <= w_crc_next;
                        r_cnt     <= w_cnt_after;
                        if (!s_if.last) begin
                            r_state <= DATA;
                        end else if (w_need_pad) begin
                            r_state <= PAD;
                        end else begin
                            r_state <= FCS;
                            r_fcs   <= ~w_crc_next;
                            r_idx   <= '0;
                        end
                    end else if (w_load) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end
                end
                PAD: begin
                    if (w_load) begin
                        r_m_data  <= '0;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b0;
                        r_crc     <= w_crc_next;
                        r_cnt     <= w_cnt_inc;
                        if (w_cnt_inc >= LP_MIN_LEN) begin
                            r_state <= FCS;
                            r_fcs   <= ~w_crc_next;
                            r_idx   <= '0;
                        end
                    end
                end
                FCS: begin
                    // FCS goes out LSB byte first; r_fcs is frozen for the whole trailer.
                    if (w_load) begin
                        r_m_data  <= r_fcs[{r_idx, 3'b000} +: 8];
                        r_m_valid <= 1'b1;
                        r_m_last  <= (r_idx == 2'd3);
                        r_idx     <= 2'(r_idx + 2'd1);
                        if (r_idx == 2'd3) begin
                            r_state <= IDLE;
                            r_crc   <= crc_init;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_if.ready  = w_s_ready;
    assign m_if.data   = r_m_data;
    assign m_if.valid  = r_m_valid;
    assign m_if.last   = r_m_last;
    assign busy        = (r_state != IDLE) || r_m_valid;
    assign o_state     = r_state;

endmodule

// File: tb/tb_eth_tx_fcs_append.sv
// Bench for eth_tx_fcs_append: two instances (PAD_EN=0 and PAD_EN=1) behind a shared driver,
// table-driven frames plus reset, back-to-back and randomized backpressure sequences.
module tb_eth_tx_fcs_append;
    import eth_tx_fcs_append_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       m_ready = 1'b1;
    int         rdy_pct = 100;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        m_ready = ($urandom_range(0, 99) < rdy_pct);
    end

    eth_tx_fcs_append_if s_if0 ();
    eth_tx_fcs_append_if m_if0 ();
    eth_tx_fcs_append_if s_if1 ();
    eth_tx_fcs_append_if m_if1 ();

    logic       busy0, busy1;
    fcs_state_t st0, st1;

    assign s_if0.data  = s_data;
    assign s_if0.valid = s_valid && !sel;
    assign s_if0.last  = s_last;
    assign m_if0.ready = m_ready;
    assign s_if1.data  = s_data;
    assign s_if1.valid = s_valid && sel;
    assign s_if1.last  = s_last;
    assign m_if1.ready = m_ready;

    eth_tx_fcs_append #(.PAD_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_if(s_if0.slave), .m_if(m_if0.master),
        .busy(busy0), .o_state(st0)
    );
    eth_tx_fcs_append #(.PAD_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_if(s_if1.slave), .m_if(m_if1.master),
        .busy(busy1), .o_state(st1)
    );

    logic       w_s_ready, w_m_valid, w_m_last, w_busy;
    logic [7:0] w_m_data;
    fcs_state_t w_state;
    assign w_s_ready = sel ? s_if1.ready : s_if0.ready;
    assign w_m_valid = sel ? m_if1.valid : m_if0.valid;
    assign w_m_last  = sel ? m_if1.last  : m_if0.last;
    assign w_m_data  = sel ? m_if1.data  : m_if0.data;
    assign w_busy    = sel ? busy1 : busy0;
    assign w_state   = sel ? st1 : st0;

    int          total = 0;
    int          bad = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  tx_buf[0:1499];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Scoreboard / monitor
    int          beat_cnt = 0;
    int          b2b_gap = -1;
    int          prev_cyc = 0;
    logic        prev_last = 1'b0;
    logic [31:0] obs_fcs = '0;
    logic [31:0] res = 32'hFFFFFFFF;
    logic        held_v = 1'b0;
    logic [9:0]  held = '0;
    logic [8:0]  e;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v    = 1'b0;
            res       = crc_init;
            prev_last = 1'b0;
        end else begin
            if (held_v) check("hold_stable", {22'h0, w_m_valid, w_m_last, w_m_data}, {22'h0, held});
            if ((w_state == PAD) || (w_state == FCS)) check("s_ready_in_pad_fcs", {31'h0, w_s_ready}, 32'h0);
            if (w_m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %h want no beat", w_m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {23'h0, w_m_last, w_m_data}, {23'h0, e});
                end
                if (prev_last) b2b_gap = cyc - prev_cyc;
                prev_last = w_m_last;
                prev_cyc  = cyc;
                beat_cnt++;
                obs_fcs = {w_m_data, obs_fcs[31:8]};
                res = crc_byte(res, w_m_data);
                if (w_m_last) begin
                    check("residue", res, crc_residue);
                    res = crc_init;
                end
            end
            held_v = w_m_valid && !m_ready;
            held   = {w_m_valid, w_m_last, w_m_data};
        end
    end

    task automatic push_frame(input int len, input logic pad_on, output int beats);
        logic [31:0] c;
        logic [31:0] f;
        int n;
        c = crc_init;
        n = 0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b0, tx_buf[i]});
            c = crc_byte(c, tx_buf[i]);
            n++;
        end
        if (pad_on) begin
            while (n < 60) begin
                exp_q.push_back(9'h000);
                c = crc_byte(c, 8'h00);
                n++;
            end
        end
        f = ~c;
        exp_q.push_back({1'b0, f[7:0]});
        exp_q.push_back({1'b0, f[15:8]});
        exp_q.push_back({1'b0, f[23:16]});
        exp_q.push_back({1'b1, f[31:24]});
        beats = n + 4;
    endtask

    task automatic drive_frame(input int len, input int send_n, input int gap_pct);
        int  guard;
        logic acc;
        for (int i = 0; i < send_n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                s_valid = 1'b0;
                s_last  = 1'($urandom_range(0, 1));
                s_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = tx_buf[i];
            s_last  = (i == len - 1);
            guard   = 0;
            forever begin
                @(negedge clk);
                acc = w_s_ready;
                @(posedge clk);
                #1;
                if (acc) break;
                guard++;
                if (guard > 5000) begin
                    total++;
                    bad++;
                    $display("FAIL s_accept_timeout: got no s_ready for %0d cycles, want acceptance", guard);
                    s_valid = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0) && (g < 20000)) begin
            @(posedge clk);
            g++;
        end
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_abc();
        for (int i = 0; i < 9; i++) tx_buf[i] = 8'(8'h31 + i);
    endtask

    task automatic run_abc(input string name);
        int beats;
        int b0;
        sel = 1'b0;
        rdy_pct = 100;
        fill_abc();
        push_frame(9, 1'b0, beats);
        b0 = beat_cnt;
        drive_frame(9, 9, 0);
        s_valid = 1'b0;
        drain(name);
        check({name, "_beats"}, 32'(beat_cnt - b0), 32'd13);
        check({name, "_fcs"}, obs_fcs, 32'hCBF43926);
    endtask

    task automatic check_reset_now(input string name);
        check({name, "_m_valid0"}, {31'h0, m_if0.valid}, 32'h0);
        check({name, "_m_last0"},  {31'h0, m_if0.last},  32'h0);
        check({name, "_m_data0"},  {24'h0, m_if0.data},  32'h0);
        check({name, "_s_ready0"}, {31'h0, s_if0.ready}, 32'h0);
        check({name, "_busy0"},    {31'h0, busy0},       32'h0);
        check({name, "_m_valid1"}, {31'h0, m_if1.valid}, 32'h0);
        check({name, "_s_ready1"}, {31'h0, s_if1.ready}, 32'h0);
        check({name, "_busy1"},    {31'h0, busy1},       32'h0);
        check({name, "_state1"},   {30'h0, st1},         {30'h0, IDLE});
    endtask

    typedef struct {
        logic        sel;
        int          len;
        logic [7:0]  base;
        logic [7:0]  step;
        int          rdy;
        int          exp_beats;
        logic        fcs_known;
        logic [31:0] exp_fcs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int beats;
        int b0;
        int g;

        vecs[0] = '{1'b0,  9, 8'h31, 8'd1, 100, 13, 1'b1, 32'hCBF43926};
        vecs[1] = '{1'b1,  1, 8'hAA, 8'd0, 100, 64, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 60, 8'h00, 8'd1, 100, 64, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 61, 8'h10, 8'd3, 100, 65, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 59, 8'hFF, 8'd0, 100, 64, 1'b0, 32'h0};
        vecs[5] = '{1'b0,  1, 8'h55, 8'd0, 100,  5, 1'b0, 32'h0};
        vecs[6] = '{1'b1,  9, 8'h31, 8'd1,  50, 64, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 64, 8'h00, 8'd7,  50, 68, 1'b0, 32'h0};

        rst_n = 1'b0;
        sel = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'h00;
        #2;
        check_reset_now("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].sel;
            rdy_pct = vecs[v].rdy;
            for (int i = 0; i < vecs[v].len; i++) tx_buf[i] = 8'(vecs[v].base + vecs[v].step * i);
            push_frame(vecs[v].len, vecs[v].sel, beats);
            b0 = beat_cnt;
            drive_frame(vecs[v].len, vecs[v].len, 0);
            s_valid = 1'b0;
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_beats", v), 32'(beat_cnt - b0), 32'(vecs[v].exp_beats));
            if (vecs[v].fcs_known) check($sformatf("vec%0d_fcs", v), obs_fcs, vecs[v].exp_fcs);
        end

        // Reset at byte 20 of a 100-byte frame
        sel = 1'b0;
        rdy_pct = 100;
        for (int i = 0; i < 100; i++) tx_buf[i] = 8'($urandom);
        push_frame(100, 1'b0, beats);
        drive_frame(100, 20, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstA_m_valid", {31'h0, w_m_valid}, 32'h0);
        check("rstA_busy", {31'h0, w_busy}, 32'h0);
        check("rstA_s_ready", {31'h0, w_s_ready}, 32'h0);
        s_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstA_quiet", {31'h0, w_m_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        run_abc("rstA_next");

        // Reset while FCS byte 2 sits in the output register
        fill_abc();
        push_frame(9, 1'b0, beats);
        b0 = beat_cnt;
        drive_frame(9, 9, 0);
        s_valid = 1'b0;
        g = 0;
        while (((beat_cnt - b0) < 11) && (g < 200)) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("rstB_reached_fcs", 32'(beat_cnt - b0), 32'd11);
        @(posedge clk);
        #1;
        check("rstB_fcs2_byte", {24'h0, w_m_data}, 32'h000000F4);
        rst_n = 1'b0;
        #1;
        check("rstB_m_valid", {31'h0, w_m_valid}, 32'h0);
        check("rstB_busy", {31'h0, w_busy}, 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstB_quiet", {31'h0, w_m_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        run_abc("rstB_next");

        // Back-to-back frames with s_valid held high
        sel = 1'b0;
        rdy_pct = 100;
        fill_abc();
        push_frame(9, 1'b0, beats);
        drive_frame(9, 9, 0);
        for (int i = 0; i < 5; i++) tx_buf[i] = 8'(8'h41 + i);
        push_frame(5, 1'b0, beats);
        drive_frame(5, 5, 0);
        s_valid = 1'b0;
        drain("b2b");
        check("b2b_gap", ((b2b_gap >= 1) && (b2b_gap <= 2)) ? 32'd1 : 32'd0, 32'd1);

        // Random frames with backpressure and source gaps
        rdy_pct = 50;
        for (int f = 0; f < 100; f++) begin
            int len;
            sel = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 200);
            for (int i = 0; i < len; i++) tx_buf[i] = 8'($urandom);
            push_frame(len, sel, beats);
            b0 = beat_cnt;
            drive_frame(len, len, 30);
            s_valid = 1'b0;
            drain("rand");
            check("rand_beats", 32'(beat_cnt - b0), 32'(beats));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
